// File: rtl/pll_reset_sequencer_if.sv
// Sequencer control/status bundle. The slave side is the sequencer itself;
// the master side is whatever drives soft_reset / locked and consumes the resets.
interface pll_reset_sequencer_if;
  logic       soft_reset;
  logic       locked;
  logic       pll_reset;
  logic       ddr_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_fail;
  logic [7:0] relock_count;

  modport master (
    output soft_reset, locked,
    input  pll_reset, ddr_rst, sys_rst, ready, lock_fail, relock_count
  );

  modport slave (
    input  soft_reset, locked,
    output pll_reset, ddr_rst, sys_rst, ready, lock_fail, relock_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up / supervision sequencer on the free-running board clock.
// Pulses the PLL reset, waits for lock, qualifies it as stable, then releases
// the DDR reset followed by the system reset. Any loss of lock after release
// re-asserts the downstream resets and restarts the whole sequence.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 5000,
  parameter int unsigned STABLE_CYCLES  = 1024,  // entry cycle counts as the first high; use >=2
  parameter int unsigned RELEASE_GAP    = 64,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  logic                  clk_in1,
  input  logic                  reset,
  pll_reset_sequencer_if.slave  bus
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK->STABLE edge already saw one locked cycle, so STABLE
  // itself needs STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             locked_m, locked_s;
  logic             pll_reset_q, ddr_rst_q, sys_rst_q, ready_q, lock_fail_q;
  logic [7:0]       relock_q;

  assign bus.pll_reset    = pll_reset_q;
  assign bus.ddr_rst      = ddr_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.ready        = ready_q;
  assign bus.lock_fail    = lock_fail_q;
  assign bus.relock_count = relock_q;

  // Two-flop synchroniser for the asynchronous PLL LOCKED pin.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= bus.locked;
      locked_s <= locked_m;
    end
  end

  // Sequencer FSM with registered reset outputs; priority reset > soft_reset > lock loss > expiry.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      retry_cnt   <= '0;
      pll_reset_q <= 1'b1;
      ddr_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_fail_q <= 1'b0;
      relock_q    <= 8'd0;
    end else if (bus.soft_reset) begin
      // Restart from PLL reset; lock_fail and relock_count are history, kept.
      state       <= S_PLL_RST;
      cnt         <= '0;
      retry_cnt   <= '0;
      pll_reset_q <= 1'b1;
      ddr_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == PLL_LAST) begin
            state       <= S_WAIT_LOCK;
            cnt         <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            // Timed out: re-pulse the PLL. Retry count saturates; lock_fail is sticky.
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
            if (retry_cnt != RTY_MAX) retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt >= RTY_LAST) lock_fail_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            // Glitch before release: downstream resets never dropped, so not a relock.
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
          end else if (cnt == STB_LAST) begin
            state     <= S_RELEASE;
            cnt       <= '0;
            ddr_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (!locked_s) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
            ddr_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
          end else if (cnt == GAP_LAST) begin
            state     <= S_RUN;
            cnt       <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
            ddr_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
          end
        end

        default: begin
          state       <= S_PLL_RST;
          cnt         <= '0;
          pll_reset_q <= 1'b1;
          ddr_rst_q   <= 1'b1;
          sys_rst_q   <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
